// File: rtl/rv_mdu_ctrl.sv
// rtl/rv_mdu_ctrl.sv - iterative RV32M multiply/divide sequencer
// One shared XLEN+1-bit adder drives shift-add multiply and restoring divide on operand magnitudes.
module rv_mdu_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic              neg_q, neg_d, rneg_q, rneg_d;

   // Request decode: signedness per funct3, magnitudes and the two early-exit divide cases
   logic            a_sgn, b_sgn, s1, s2, div_zero, div_ovf;
   logic [XLEN-1:0] mag1, mag2;
   assign a_sgn    = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
   assign b_sgn    = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
   assign s1       = a_sgn & rs1_i[XLEN-1];
   assign s2       = b_sgn & rs2_i[XLEN-1];
   assign mag1     = s1 ? -rs1_i : rs1_i;
   assign mag2     = s2 ? -rs2_i : rs2_i;
   assign div_zero = funct3_i[2] && (rs2_i == '0);
   assign div_ovf  = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);

   // Datapath: hi/lo form the 2*XLEN product (multiply) or remainder/quotient pair (divide)
   logic              div_mode, add_sub;
   logic [XLEN:0]     rem_shift, add_a, add_b, add_sum;
   logic [XLEN-1:0]   hi_n, lo_n, quot_f, rem_f, fixed;
   logic [2*XLEN-1:0] prod, prod_f;
   assign div_mode  = funct3_q[2];
   assign rem_shift = {hi_q, lo_q[XLEN-1]};
   assign add_a     = div_mode ? rem_shift : {1'b0, hi_q};
   assign add_b     = {1'b0, a_q};
   assign add_sub   = div_mode;
   assign add_sum   = add_a + (add_sub ? ~add_b : add_b) + {{XLEN{1'b0}}, add_sub};

   always_comb begin
      hi_n = hi_q;
      lo_n = lo_q;
      if (div_mode) begin
         if (!add_sum[XLEN]) begin
            hi_n = add_sum[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_n = rem_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
         end
      end else if (lo_q[0]) begin
         {hi_n, lo_n} = {add_sum, lo_q[XLEN-1:1]};
      end else begin
         {hi_n, lo_n} = {1'b0, hi_q, lo_q[XLEN-1:1]};
      end
   end

   assign prod   = {hi_n, lo_n};
   assign prod_f = neg_q ? -prod : prod;
   assign quot_f = neg_q ? -lo_n : lo_n;
   assign rem_f  = rneg_q ? -hi_n : hi_n;
   assign fixed  = div_mode ? (funct3_q[1] ? rem_f : quot_f)
                            : ((funct3_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      a_d      = a_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && !flush_i) begin
               funct3_d = funct3_i;
               cnt_d    = '0;
               neg_d    = s1 ^ s2;
               rneg_d   = s1;
               hi_d     = '0;
               if (div_zero) begin
                  result_d = funct3_i[1] ? rs1_i : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = funct3_i[1] ? '0 : MIN_NEG;
                  state_d  = S_DONE;
               end else begin
                  a_d     = funct3_i[2] ? mag2 : mag1;
                  lo_d    = funct3_i[2] ? mag1 : mag2;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               hi_d  = hi_n;
               lo_d  = lo_n;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) begin
                  result_d = fixed;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (flush_i || resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         a_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         a_q      <= a_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE) && !flush_i;
   assign resp_valid_o = (state_q == S_DONE);
   assign busy_o       = (state_q != S_IDLE);
   assign result_o     = result_q;
endmodule

// File: tb/tb_rv_mdu_ctrl.sv
// tb/tb_rv_mdu_ctrl.sv - self-checking bench for rv_mdu_ctrl
// Expected results and latencies are queued at request time and popped when the response arrives.
module tb_rv_mdu_ctrl;
   localparam int XLEN = 32;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            req_valid_i;
   logic            req_ready_o;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] result_o;
   logic            busy_o;

   int checks = 0;
   int failures = 0;
   logic [XLEN-1:0] exp_data_q[$];
   int              exp_lat_q[$];

   rv_mdu_ctrl #(.XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .flush_i(flush_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .result_o(result_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Returns right after the accepting edge (+1); optionally queues the expectation.
   task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat, input bit track);
      int n = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      funct3_i = f;
      rs1_i = a;
      rs2_i = b;
      while (!req_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (track) begin
         exp_data_q.push_back(exp);
         exp_lat_q.push_back(lat);
      end
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   // Counts cycles from the request handshake cycle until resp_valid_o; bounded.
   task automatic collect(output logic [XLEN-1:0] data, output int cyc, output bit ctl_bad);
      cyc = 1;
      ctl_bad = 1'b0;
      while (!resp_valid_o && cyc < 200) begin
         if (req_ready_o || !busy_o) ctl_bad = 1'b1;
         @(posedge clk_i);
         #1;
         cyc++;
      end
      data = result_o;
   endtask

   task automatic release_resp();
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      resp_ready_i = 1'b0;
   endtask

   task automatic pop_exp(output logic [XLEN-1:0] d, output int l);
      d = 'x;
      l = -1;
      if (exp_data_q.size() > 0) begin
         d = exp_data_q.pop_front();
         l = exp_lat_q.pop_front();
      end
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      req_valid_i = 1'b0;
      funct3_i = '0;
      rs1_i = '0;
      rs2_i = '0;
      flush_i = 1'b0;
      resp_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({req_ready_o, resp_valid_o, busy_o} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctrl got ready/valid/busy=%b want 100", {req_ready_o, resp_valid_o, busy_o});
      end
      checks++;
      if (result_o !== '0) begin
         failures++;
         $display("FAIL reset_result got %h want 0", result_o);
      end
   endtask

   task automatic test_mul_latency();
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
      collect(d, cyc, bad);
      pop_exp(ed, el);
      checks++;
      if (d !== ed) begin
         failures++;
         $display("FAIL mul_result got %h want %h", d, ed);
      end
      checks++;
      if (cyc !== el) begin
         failures++;
         $display("FAIL mul_latency got %0d want %0d", cyc, el);
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL mul_busy_ready got ready-high-or-busy-low during CALC want ready=0 busy=1");
      end
      release_resp();
   endtask

   task automatic test_mul_high();
      logic [2:0]      f [3] = '{3'b001, 3'b011, 3'b010};
      logic [XLEN-1:0] a [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [XLEN-1:0] b [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
      logic [XLEN-1:0] e [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      for (int i = 0; i < 3; i++) begin
         issue(f[i], a[i], b[i], e[i], 33, 1'b1);
         collect(d, cyc, bad);
         pop_exp(ed, el);
         checks++;
         if (d !== ed || cyc !== el) begin
            failures++;
            $display("FAIL mul_high[%0d] got %h lat %0d want %h lat %0d", i, d, cyc, ed, el);
         end
         release_resp();
      end
   endtask

   task automatic test_divide();
      logic [2:0]      f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [XLEN-1:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [XLEN-1:0] b [4] = '{32'd2, 32'd2, 32'd2, 32'd2};
      logic [XLEN-1:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1};
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      for (int i = 0; i < 4; i++) begin
         issue(f[i], a[i], b[i], e[i], 33, 1'b1);
         collect(d, cyc, bad);
         pop_exp(ed, el);
         checks++;
         if (d !== ed || cyc !== el) begin
            failures++;
            $display("FAIL divide[%0d] got %h lat %0d want %h lat %0d", i, d, cyc, ed, el);
         end
         release_resp();
      end
   endtask

   task automatic test_special();
      logic [2:0]      f [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
      logic [XLEN-1:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [XLEN-1:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [XLEN-1:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      for (int i = 0; i < 4; i++) begin
         issue(f[i], a[i], b[i], e[i], 1, 1'b1);
         collect(d, cyc, bad);
         pop_exp(ed, el);
         checks++;
         if (d !== ed || cyc !== el) begin
            failures++;
            $display("FAIL special[%0d] got %h lat %0d want %h lat %0d", i, d, cyc, ed, el);
         end
         release_resp();
      end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      issue(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 1'b1);
      collect(d, cyc, bad);
      pop_exp(ed, el);
      checks++;
      if (d !== ed) begin
         failures++;
         $display("FAIL bp_result got %h want %h", d, ed);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         checks++;
         if (resp_valid_o !== 1'b1 || result_o !== ed) begin
            failures++;
            $display("FAIL bp_hold[%0d] got valid=%b result=%h want valid=1 result=%h", i, resp_valid_o, result_o, ed);
         end
      end
      @(negedge clk_i);
      req_valid_i = 1'b1;
      funct3_i = 3'b011;
      rs1_i = 32'hFFFF_FFFF;
      rs2_i = 32'hFFFF_FFFF;
      resp_ready_i = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_handshake_ready got %b want 0", req_ready_o);
      end
      @(posedge clk_i);
      #1;
      resp_ready_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle got busy=%b valid=%b ready=%b want 0 0 1", busy_o, resp_valid_o, req_ready_o);
      end
      exp_data_q.push_back(32'hFFFF_FFFE);
      exp_lat_q.push_back(33);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept got busy=%b want 1", busy_o);
      end
      collect(d, cyc, bad);
      pop_exp(ed, el);
      checks++;
      if (d !== ed || cyc !== el) begin
         failures++;
         $display("FAIL b2b_result got %h lat %0d want %h lat %0d", d, cyc, ed, el);
      end
      release_resp();
   endtask

   task automatic test_flush();
      logic [XLEN-1:0] d, ed;
      int cyc, el;
      bit bad;
      bit seen = 1'b0;
      @(negedge clk_i);
      flush_i = 1'b1;
      req_valid_i = 1'b1;
      funct3_i = 3'b000;
      rs1_i = 32'd3;
      rs2_i = 32'd4;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_ready got %b want 0", req_ready_o);
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_accept got busy=%b want 0", busy_o);
      end
      flush_i = 1'b0;
      req_valid_i = 1'b0;
      issue(3'b000, 32'd11, 32'd13, 32'd0, 0, 1'b0);
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_calc got busy=%b valid=%b want 0 0", busy_o, resp_valid_o);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         if (resp_valid_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL flush_no_resp got resp_valid_o=1 after flush want 0");
      end
      issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
      collect(d, cyc, bad);
      pop_exp(ed, el);
      checks++;
      if (d !== ed || cyc !== el) begin
         failures++;
         $display("FAIL flush_followup got %h lat %0d want %h lat %0d", d, cyc, ed, el);
      end
      release_resp();
   endtask

   task automatic test_async_reset();
      issue(3'b000, 32'd9, 32'd9, 32'd0, 0, 1'b0);
      repeat (5) @(posedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0 || result_o !== '0) begin
         failures++;
         $display("FAIL async_reset got busy=%b valid=%b result=%h want 0 0 0", busy_o, resp_valid_o, result_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_ready got %b want 1", req_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_mul_latency();
      test_mul_high();
      test_divide();
      test_special();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
